// File: rtl/sym_cn_lut_loader_if.sv
// Entry stream from the host/ROM streamer into the CN LUT loader.
// The source holds entry_in/entry_valid until it sees entry_ready.
interface sym_cn_lut_loader_if #(
  parameter int LUT_PORT_SIZE = 2
);
  logic [LUT_PORT_SIZE-1:0] entry_in;
  logic                     entry_valid;
  logic                     entry_ready;

  modport master (output entry_in, output entry_valid, input entry_ready);
  modport slave  (input entry_in, input entry_valid, output entry_ready);
endinterface

// File: rtl/sym_cn_lut_loader.sv
// Write-side feeder for the symmetric CN IB-LUT: packs the serial entry stream
// into bank0/bank1 page pairs and strobes one write per page into a frame offset.
module sym_cn_lut_loader #(
  parameter int QUAN_SIZE       = 3,
  parameter int LUT_PORT_SIZE   = 2,
  parameter int ENTRY_ADDR      = 4,
  parameter int MULTI_FRAME_NUM = 2,
  localparam int PAGE_W = ENTRY_ADDR - $clog2(MULTI_FRAME_NUM),
  localparam int PAGES  = 2**PAGE_W
) (
  input  logic                     write_clk,
  input  logic                     rstn,
  input  logic                     load_start,
  input  logic                     load_offset,
  input  logic                     load_abort,
  sym_cn_lut_loader_if.slave       ent,
  output logic [LUT_PORT_SIZE-1:0] lut_in_bank0,
  output logic [LUT_PORT_SIZE-1:0] lut_in_bank1,
  output logic [PAGE_W-1:0]        page_write_addr,
  output logic                     write_addr_offset,
  output logic                     we,
  output logic                     busy,
  output logic                     load_done,
  output logic                     load_aborted
);

  // The stored magnitude drops the sign bit; a single offset bit selects the frame.
  if (LUT_PORT_SIZE > QUAN_SIZE - 1 || MULTI_FRAME_NUM != 2) begin : g_param_chk
    $error("sym_cn_lut_loader: unsupported LUT_PORT_SIZE/QUAN_SIZE/MULTI_FRAME_NUM");
  end

  typedef enum logic [2:0] {IDLE, CAP0, CAP1, WR, FIN} state_t;

  state_t            st, nxt;
  logic [PAGE_W-1:0] page_cnt;
  logic              last_page;
  logic              abort_ok;

  assign last_page = (page_cnt == PAGE_W'(PAGES - 1));
  assign abort_ok  = load_abort && (st == CAP0 || st == CAP1 || st == WR);

  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) st <= IDLE;
    else       st <= nxt;
  end

  always_comb begin
    nxt = st;
    unique case (st)
      IDLE:    if (load_start) nxt = CAP0;
      CAP0:    if (ent.entry_valid) nxt = CAP1;
      CAP1:    if (ent.entry_valid) nxt = WR;
      WR:      nxt = last_page ? FIN : CAP0;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (abort_ok) nxt = IDLE;
  end

  always_comb begin
    ent.entry_ready = 1'b0;
    we              = 1'b0;
    load_done       = 1'b0;
    busy            = (st != IDLE);
    unique case (st)
      CAP0, CAP1: ent.entry_ready = 1'b1;
      WR:         we              = 1'b1;
      FIN:        load_done       = 1'b1;
      default:    ;
    endcase
  end

  // Page data and address stay put after a load until the next one overwrites them.
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      lut_in_bank0      <= '0;
      lut_in_bank1      <= '0;
      page_write_addr   <= '0;
      write_addr_offset <= 1'b0;
      page_cnt          <= '0;
      load_aborted      <= 1'b0;
    end else begin
      load_aborted <= abort_ok;
      if (st == IDLE && load_start) begin
        write_addr_offset <= load_offset;
        page_cnt          <= '0;
      end
      if (!abort_ok) begin
        if (st == CAP0 && ent.entry_valid) begin
          lut_in_bank0    <= ent.entry_in;
          page_write_addr <= page_cnt;
        end
        if (st == CAP1 && ent.entry_valid) lut_in_bank1 <= ent.entry_in;
        if (st == WR && !last_page) page_cnt <= page_cnt + PAGE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sym_cn_lut_loader.sv
// Directed bench for sym_cn_lut_loader: a page-level model predicts every
// write (address, bank pair, offset) from the entry list fed to the stream.
module tb_sym_cn_lut_loader;
  localparam int LPS   = 2;
  localparam int PW    = 3;
  localparam int PAGES = 8;

  logic clk = 1'b0, rstn = 1'b0;
  logic load_start = 1'b0, load_offset = 1'b0, load_abort = 1'b0;
  logic [LPS-1:0] bank0, bank1;
  logic [PW-1:0]  paddr;
  logic woff, we, busy, load_done, load_aborted;

  sym_cn_lut_loader_if #(.LUT_PORT_SIZE(LPS)) eif ();

  sym_cn_lut_loader #(.QUAN_SIZE(3), .LUT_PORT_SIZE(LPS), .ENTRY_ADDR(4), .MULTI_FRAME_NUM(2)) dut (
    .write_clk(clk), .rstn(rstn), .load_start(load_start), .load_offset(load_offset),
    .load_abort(load_abort), .ent(eif), .lut_in_bank0(bank0), .lut_in_bank1(bank1),
    .page_write_addr(paddr), .write_addr_offset(woff), .we(we), .busy(busy),
    .load_done(load_done), .load_aborted(load_aborted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  logic [LPS-1:0] m_entries [2*PAGES];
  int  m_page, we_n, done_t, abort_t, start_ref;
  int  we_t [16];
  bit  m_off, done_seen, abort_seen, chk_en;
  logic [3:0] p5_data;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: every write strobe must match the next page of the model.
  always @(negedge clk) begin
    if (rstn && chk_en) begin
      if (we) begin
        if (m_page > PAGES - 1) chk("extra_we", m_page, PAGES - 1);
        else begin
          chk("we_addr",   int'(paddr), m_page);
          chk("we_bank0",  int'(bank0), int'(m_entries[2*m_page]));
          chk("we_bank1",  int'(bank1), int'(m_entries[2*m_page+1]));
          chk("we_offset", int'(woff),  int'(m_off));
        end
        if (paddr == 3'd5) p5_data = {bank0, bank1};
        if (we_n < 16) we_t[we_n] = cyc - start_ref;
        we_n++;
        m_page++;
      end
      if (load_done) begin
        chk("done_pages", m_page, PAGES);
        done_seen = 1'b1;
        done_t = cyc - start_ref;
      end
      if (load_aborted) begin
        chk("abort_no_done", int'(load_done), 0);
        abort_seen = 1'b1;
        abort_t = cyc - start_ref;
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_we"}, int'(we), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_ready"}, int'(eif.entry_ready), 0);
    chk({tag, "_bank0"}, int'(bank0), 0);
    chk({tag, "_bank1"}, int'(bank1), 0);
    chk({tag, "_addr"}, int'(paddr), 0);
    chk({tag, "_off"}, int'(woff), 0);
    chk({tag, "_done"}, int'(load_done), 0);
    chk({tag, "_aborted"}, int'(load_aborted), 0);
  endtask

  // One load: entries (e*mul)%4; optional valid gaps before odd entries,
  // abort at the WR of abort_pg, stray start in CAP1 of start_pg, reset in CAP0 of rst_pg.
  task automatic do_load(input bit off, input int mul, input bit gaps,
                         input int abort_pg, input int start_pg, input int rst_pg);
    int idx, gap;
    bit v, rst_hit;
    idx = 0; gap = 0; rst_hit = 1'b0;
    for (int e = 0; e < 2*PAGES; e++) m_entries[e] = LPS'((e * mul) % 4);
    m_page = 0; m_off = off; we_n = 0;
    done_seen = 1'b0; abort_seen = 1'b0;
    @(negedge clk);
    start_ref = cyc; load_start = 1'b1; load_offset = off;
    for (int c = 0; c < 300 && !done_seen && !abort_seen && !rst_hit; c++) begin
      @(negedge clk);
      load_abort = (abort_pg >= 0 && we && int'(paddr) == abort_pg);
      if (start_pg >= 0 && eif.entry_ready && idx == 2*start_pg + 1) begin
        load_start = 1'b1; load_offset = ~off;
      end else begin
        load_start = 1'b0; load_offset = off;
      end
      if (rst_pg >= 0 && eif.entry_ready && idx == 2*rst_pg) begin
        rstn = 1'b0;
        #1 chk_zero("midrst");
        eif.entry_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        rst_hit = 1'b1;
      end else begin
        v = (idx < 2*PAGES);
        if (gaps && idx % 2 == 1 && gap < 2) begin v = 1'b0; gap++; end
        eif.entry_valid = v;
        eif.entry_in    = v ? m_entries[idx] : '0;
        if (v && eif.entry_ready) begin idx++; gap = 0; end
      end
    end
    load_abort = 1'b0; load_start = 1'b0; eif.entry_valid = 1'b0;
    if (!done_seen && !abort_seen && !rst_hit) chk("load_timeout", 0, 1);
    if (done_seen) begin
      while (cyc - start_ref < done_t + 1) @(negedge clk);
      chk("post_done_busy", int'(busy), 0);
      chk("post_done_pulse", int'(load_done), 0);
    end
  endtask

  initial begin
    eif.entry_in = '0; eif.entry_valid = 1'b0;
    chk_en = 1'b0; p5_data = '0;
    #12 chk_zero("reset");
    @(negedge clk); rstn = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // 1: back-to-back load into offset 1
    do_load(1'b1, 1, 1'b0, -1, -1, -1);
    chk("t1_we_count", we_n, 8);
    for (int p = 0; p < PAGES; p++) chk("t1_we_cycle", we_t[p], 3*p + 3);
    chk("t1_done_cycle", done_t, 25);
    chk("t1_busy_low_c26", cyc - start_ref, 26);
    chk("t1_page5_data", int'(p5_data), 4'b10_11);

    // 2: two-cycle valid gaps before odd entries
    do_load(1'b1, 1, 1'b1, -1, -1, -1);
    chk("t2_we_count", we_n, 8);
    for (int p = 1; p < PAGES; p++) chk("t2_we_spacing", we_t[p] - we_t[p-1], 5);

    // 3: abort during WR of page 3, then a clean load into offset 0
    do_load(1'b1, 3, 1'b0, 3, -1, -1);
    chk("t3_we_count", we_n, 4);
    chk("t3_abort_cycle", abort_t, we_t[3] + 1);
    chk("t3_no_done", int'(done_seen), 0);
    repeat (5) @(negedge clk);
    chk("t3_quiet_we", we_n, 4);
    chk("t3_idle_busy", int'(busy), 0);
    chk("t3_aborted_pulse", int'(load_aborted), 0);
    do_load(1'b0, 3, 1'b0, -1, -1, -1);
    chk("t3b_we_count", we_n, 8);

    // 4: stray start in CAP1 of page 2 is ignored
    do_load(1'b1, 1, 1'b0, -1, 2, -1);
    chk("t4_we_count", we_n, 8);
    chk("t4_done", int'(done_seen), 1);

    // 5: reset in CAP0 of page 5, then a fresh load from page 0
    do_load(1'b1, 3, 1'b0, -1, -1, 5);
    chk("t5_we_before_rst", we_n, 5);
    @(negedge clk);
    chk("t5_idle_busy", int'(busy), 0);
    do_load(1'b0, 1, 1'b0, -1, -1, -1);
    chk("t5_we_count", we_n, 8);

    // 6: valid in IDLE without start does nothing
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      eif.entry_valid = 1'b1; eif.entry_in = 2'd3;
      chk("t6_ready", int'(eif.entry_ready), 0);
      chk("t6_we", int'(we), 0);
      chk("t6_busy", int'(busy), 0);
    end
    eif.entry_valid = 1'b0;
    @(negedge clk);
    chk("t6_bank0_held", int'(bank0), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sym_cn_lut_loader.md
Name: sym_cn_lut_loader

Overview:
- Write-side feeder for the symmetric CN IB-LUT block (sym_cn_lut_in / sym_cn_rank write port).
- Accepts a serial stream of LUT magnitude entries from the host/ROM streamer with a valid/ready handshake.
- Packs consecutive entries into bank0/bank1 pairs and generates page_write_addr, write_addr_offset and a one-cycle we per page.
- Loads one full LUT (all pages) into the selected frame offset per load command. Reports completion or abort.

Parameters:
QUAN_SIZE, 3, full message width including sign (not stored; kept for interface consistency)
LUT_PORT_SIZE, 2, magnitude width of one LUT entry
ENTRY_ADDR, 4, log2 of entries per LUT including the frame-offset bit
MULTI_FRAME_NUM, 2, number of frame offsets; PAGE_W = ENTRY_ADDR-$clog2(MULTI_FRAME_NUM) (=3), PAGES = 2**PAGE_W (=8)

Ports:
write_clk  input  1  single clock; all logic on posedge
rstn  input  1  asynchronous active-low reset
load_start  input  1  start a LUT load; sampled only in IDLE
load_offset  input  1  target frame offset for this load
load_abort  input  1  abandon the load in progress
entry_in  input  LUT_PORT_SIZE  next LUT entry, ascending entry order
entry_valid  input  1  entry_in valid
entry_ready  output  1  loader accepts entry_in this cycle
lut_in_bank0  output  LUT_PORT_SIZE  even entry of the current page
lut_in_bank1  output  LUT_PORT_SIZE  odd entry of the current page
page_write_addr  output  PAGE_W  page being written
write_addr_offset  output  1  latched load_offset
we  output  1  one-cycle write strobe
busy  output  1  high in any state other than IDLE
load_done  output  1  one-cycle pulse after the last page write
load_aborted  output  1  one-cycle pulse on an accepted abort

Behaviour:
- Reset (async assert, sync-safe release): state=IDLE; all outputs and internal registers are 0.
- All outputs come straight from registers or are decoded from the state register. There is no combinational path from any input to any output.
- States: IDLE, CAP0, CAP1, WR, FIN.
- IDLE: entry_ready=0, busy=0. If load_start=1, latch load_offset into write_addr_offset, clear page_cnt, and go to CAP0. entry_valid is ignored.
- CAP0: entry_ready=1. On entry_valid&entry_ready, lut_in_bank0<=entry_in and go to CAP1. Otherwise hold.
- CAP1: entry_ready=1. On the handshake, lut_in_bank1<=entry_in and go to WR. Otherwise hold.
- WR: entry_ready=0, we=1, page_write_addr=page_cnt; bank data is stable. Next state: FIN if page_cnt==PAGES-1, else CAP0 with page_cnt+1.
- FIN: load_done=1, busy=1, then IDLE.
- Entry mapping: stream entry e goes to page e>>1, bank e[0]. A full load consumes 2*PAGES entries (16 by default).
- Throughput: 3 cycles per page with valid held high. Load latency is 3*PAGES+1 cycles from the start edge to the FIN cycle.
- page_write_addr, write_addr_offset, lut_in_bank0 and lut_in_bank1 hold their last values after a load until the next start or reset.
- load_start outside IDLE is ignored. A load_start/load_abort collision in IDLE: the start is taken and the abort is ignored.
- load_abort in CAP0, CAP1 or WR goes to IDLE at the next edge and pulses load_aborted for one cycle.
  - An abort has priority over all other transitions.
  - If the abort is sampled during WR, that cycle's we=1 still commits the page; no further writes follow.
- load_abort in FIN is ignored: load_done pulses and load_aborted stays 0.
- Entries presented while entry_ready=0 are not consumed. The source must hold them.
- Reset asserted mid-load: outputs clear immediately; a partially loaded LUT is not flagged (software reloads it).

Test Plan:
1. Reset, then load_start=1 with load_offset=1 and entry_valid held high, entries 0..15 = e mod 4.
   - 8 we pulses at cycles 3,6,...,24 with page_write_addr 0..7.
   - Page p: bank0 = 2p mod 4, bank1 = (2p+1) mod 4; write_addr_offset=1 throughout.
   - load_done at cycle 25; busy low at cycle 26.
2. Same load, but entry_valid drops for 2 cycles before every odd entry.
   - Loader holds in CAP1; we spacing stretches to 5 cycles.
   - Page data unchanged; still exactly 8 we pulses.
3. load_abort asserted during the WR cycle of page 3.
   - That page-3 we commits; load_aborted pulses the next cycle; state returns to IDLE; no load_done.
   - A following load with load_offset=0 completes normally.
4. load_start pulsed during CAP1 of page 2.
   - Ignored; write_addr_offset unchanged; the load completes with 8 writes.
5. rstn asserted during CAP0 of page 5.
   - we, busy, entry_ready and all data/address outputs read 0 in the same cycle.
   - After release, IDLE; a new load starts from page 0.
6. entry_valid=1 in IDLE with no start.
   - entry_ready=0, no we, no state change for 10 cycles.
